// File: rtl/md_pkg.sv
// Shared mult/div definitions: md_op encodings and FSM state type, used by
// both the mult/div control and the hazard unit.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef logic [0:0] md_state_t;
    localparam md_state_t ST_IDLE = 1'b0;
    localparam md_state_t ST_RUN  = 1'b1;

    function automatic logic md_is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing HI/LO results,
// including the divide-by-zero and signed-overflow special cases.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   quo_s, rem_s, quo_u, rem_u;
    logic               div_zero, div_ovf;

    assign prod_s = $signed({{WIDTH{rs_val[WIDTH-1]}}, rs_val})
                  * $signed({{WIDTH{rt_val[WIDTH-1]}}, rt_val});
    assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

    // Native signed / and % truncate toward zero with remainder following the dividend.
    assign quo_s = $signed(rs_val) / $signed(rt_val);
    assign rem_s = $signed(rs_val) % $signed(rt_val);
    assign quo_u = rs_val / rt_val;
    assign rem_u = rs_val % rt_val;

    assign div_zero = (rt_val == '0);
    assign div_ovf  = (rs_val == MIN_NEG) && (rt_val == '1);

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (md_op)
            MD_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                if (div_zero) begin
                    res_hi = rs_val;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = MIN_NEG;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_hi = rs_val;
                    res_lo = '1;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: results are computed
// at issue, held in pending registers, and committed after a fixed latency.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             accept;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign busy   = (state == ST_RUN);
    assign accept = start && !flush && (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                if (md_is_mult(md_op) || md_is_div(md_op)) begin
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    cnt     <= md_is_mult(md_op) ? MULT_LAT : DIV_LAT;
                    state   <= ST_RUN;
                end else if (md_op == MD_MTHI) begin
                    hi <= rs_val;
                end else if (md_op == MD_MTLO) begin
                    lo <= rs_val;
                end
            end
        end else begin
            // Flush outranks the completing edge so an aborted op never commits.
            if (flush) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                pend_hi <= '0;
                pend_lo <= '0;
            end else if (cnt == CNT_W'(1)) begin
                hi    <= pend_hi;
                lo    <= pend_lo;
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default and 16-bit/1-cycle instances).
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo;

    logic        start2, flush2;
    logic [2:0]  md_op2;
    logic [15:0] rs_val2, rt_val2;
    logic        busy2;
    logic [15:0] hi2, lo2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_div_unit u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    mult_div_unit #(
        .WIDTH       (16),
        .MULT_CYCLES (1),
        .DIV_CYCLES  (10)
    ) u_dut16 (
        .clk    (clk),
        .reset  (reset),
        .start  (start2),
        .md_op  (md_op2),
        .rs_val (rs_val2),
        .rt_val (rt_val2),
        .flush  (flush2),
        .busy   (busy2),
        .hi     (hi2),
        .lo     (lo2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op from idle, count busy cycles (bounded) and check the result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " busy_cycles"}, 64'(cyc), 64'(lat));
        chk({tag, " hi"}, 64'(hi), 64'(ehi));
        chk({tag, " lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        int cyc;
        reset = 1'b0; start = 1'b0; flush = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0;
        start2 = 1'b0; flush2 = 1'b0; md_op2 = MD_NONE; rs_val2 = '0; rt_val2 = '0;
        #12;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        chk("reset busy16", 64'(busy2), 64'(0));
        @(negedge clk); reset = 1'b1;

        // 16-bit, single-cycle multiply: (-32768)^2 = 0x4000_0000
        @(negedge clk);
        start2 = 1'b1; md_op2 = MD_MULT; rs_val2 = 16'h8000; rt_val2 = 16'h8000;
        @(posedge clk); #1; start2 = 1'b0; md_op2 = MD_NONE;
        chk("w16 busy", 64'(busy2), 64'(1));
        @(posedge clk); #1;
        chk("w16 done", 64'(busy2), 64'(0));
        chk("w16 hi", 64'(hi2), 64'h4000);
        chk("w16 lo", 64'(lo2), 64'h0);

        run_op("mult -2*3",   MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("div -7/2",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/0",    MD_DIVU,  32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
        run_op("div ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("multu max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h1);
        run_op("div 7/-2",    MD_DIV,   32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
        run_op("divu 100/7",  MD_DIVU,  32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div -5/0",    MD_DIV,   32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTLO / MTHI write in one edge without going busy
        @(negedge clk); start = 1'b1; md_op = MD_MTLO; rs_val = 32'h1234;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        chk("mtlo busy", 64'(busy), 64'(0));
        chk("mtlo lo", 64'(lo), 64'h1234);
        chk("mtlo hi kept", 64'(hi), 64'hFFFF_FFFB);
        @(negedge clk); start = 1'b1; md_op = MD_MTHI; rs_val = 32'hABCD;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        chk("mthi hi", 64'(hi), 64'hABCD);

        // Start while busy is ignored
        @(negedge clk); start = 1'b1; md_op = MD_MULT; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); start = 1'b1; md_op = MD_MULTU; rs_val = 32'h1_0000; rt_val = 32'h1_0000;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        cyc = 1;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ignored start cycles", 64'(cyc), 64'(5));
        chk("ignored start hi", 64'(hi), 64'h0);
        chk("ignored start lo", 64'(lo), 64'd6);
        chk("ignored start idle", 64'(busy), 64'(0));
        run_op("multu 2^32", MD_MULTU, 32'h1_0000, 32'h1_0000, 5, 32'h1, 32'h0);

        // Flush at cycle 4 of a divide
        @(negedge clk); start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        chk("flush pre busy", 64'(busy), 64'(1));
        repeat (3) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush busy", 64'(busy), 64'(0));
        chk("flush hi", 64'(hi), 64'h1);
        chk("flush lo", 64'(lo), 64'h0);
        run_op("mult after flush", MD_MULT, 32'd3, 32'd4, 5, 32'h0, 32'd12);

        // Flush on the completing edge wins
        @(negedge clk); start = 1'b1; md_op = MD_MULT; rs_val = 32'd5; rt_val = 32'd5;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        repeat (4) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush last busy", 64'(busy), 64'(0));
        chk("flush last lo", 64'(lo), 64'd12);
        chk("flush last hi", 64'(hi), 64'h0);

        // Flush together with start: MTHI and MULT both ignored
        @(negedge clk); flush = 1'b1; start = 1'b1; md_op = MD_MTHI; rs_val = 32'hDEAD;
        @(posedge clk); #1;
        chk("flush+mthi hi", 64'(hi), 64'h0);
        @(negedge clk); md_op = MD_MULT; rs_val = 32'd9; rt_val = 32'd9;
        @(posedge clk); #1; flush = 1'b0; start = 1'b0; md_op = MD_NONE;
        chk("flush+mult busy", 64'(busy), 64'(0));

        // NONE and reserved ops do nothing
        @(negedge clk); start = 1'b1; md_op = 3'd7; rs_val = 32'hFFFF;
        @(posedge clk); #1;
        chk("op7 busy", 64'(busy), 64'(0));
        @(negedge clk); md_op = MD_NONE;
        @(posedge clk); #1; start = 1'b0;
        chk("none busy", 64'(busy), 64'(0));
        chk("none hi", 64'(hi), 64'h0);
        chk("none lo", 64'(lo), 64'd12);

        // Asynchronous reset mid-run, then immediate accept after release
        @(negedge clk); start = 1'b1; md_op = MD_MTHI; rs_val = 32'h55;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        @(negedge clk); start = 1'b1; md_op = MD_DIV; rs_val = 32'd9; rt_val = 32'd3;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        @(posedge clk); #3; reset = 1'b0; #1;
        chk("async rst busy", 64'(busy), 64'(0));
        chk("async rst hi", 64'(hi), 64'h0);
        chk("async rst lo", 64'(lo), 64'h0);
        @(negedge clk); reset = 1'b1;
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd7; rt_val = 32'd6;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        chk("post rst accept", 64'(busy), 64'(1));
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("post rst cycles", 64'(cyc), 64'(5));
        chk("post rst lo", 64'(lo), 64'd42);
        chk("post rst hi", 64'(hi), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, 32: operand and HI/LO width in bits; legal values are 8 or greater.
REQ-002 Parameter MULT_CYCLES, 5: busy cycles for MULT/MULTU; minimum value 1.
REQ-003 Parameter DIV_CYCLES, 10: busy cycles for DIV/DIVU; minimum value 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 start  input  1  op valid this cycle; ignored while busy=1 or flush=1.
REQ-007 md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-008 rs_val  input  WIDTH  first operand (dividend/multiplicand; MTHI/MTLO source).
REQ-009 rt_val  input  WIDTH  second operand (divisor/multiplier).
REQ-010 flush  input  1  abort the in-flight operation.
REQ-011 busy  output  1  operation in flight; the hazard unit stalls D-stage md instructions on busy|start.
REQ-012 hi  output  WIDTH  registered HI.
REQ-013 lo  output  WIDTH  registered LO.

Function
REQ-014 FSM states: IDLE and RUN; a down-counter cnt (width clog2(max(MULT_CYCLES,DIV_CYCLES))+1) tracks RUN.
REQ-015 IDLE, start=1, md_op in 1..4 at edge T: capture result into pending registers, load cnt with the matching latency, enter RUN; busy=1 from T+1.
REQ-016 RUN: cnt decrements each edge; at the edge where cnt==1, hi/lo take pending values, state returns to IDLE, and busy=0 the same cycle hi/lo change.
REQ-017 Total latency: new hi/lo visible exactly LAT cycles after the start edge; busy high for exactly LAT cycles.
REQ-018 MULT: signed WIDTH x WIDTH -> 2*WIDTH product; hi = upper half, lo = lower half. MULTU: the same, unsigned.
REQ-019 DIV: signed, quotient truncated toward zero -> lo; remainder takes the sign of the dividend -> hi. DIVU: unsigned.
REQ-020 Divide by zero (rt_val==0, DIV or DIVU): lo = all ones, hi = rs_val; normal latency.
REQ-021 Signed overflow (DIV, rs_val = most-negative, rt_val = -1): lo = most-negative, hi = 0.
REQ-022 MTHI/MTLO with start=1 in IDLE: hi (or lo) <= rs_val at the next edge; busy stays 0.
REQ-023 start=1 while busy=1: no effect on state, counter, pending or hi/lo.
REQ-024 flush=1 in RUN: return to IDLE at the next edge; hi/lo keep their pre-op values; pending data discarded.
REQ-025 flush=1 and start=1 in the same cycle: start is ignored, including MTHI/MTLO.
REQ-026 flush=1 and the completing edge (cnt==1) in the same cycle: flush wins and hi/lo do not update.
REQ-027 md_op NONE or reserved with start=1: no state change.

Reset
REQ-028 reset=0 asynchronously forces IDLE, cnt=0, busy=0, hi=0, lo=0, and pending=0, regardless of clk.
REQ-029 Reset asserted mid-RUN aborts the operation; after release the unit accepts start on the first edge.

Structure
REQ-030 A shared package md_pkg holds the md_op encodings (MD_NONE..MD_MTLO) and the FSM state typedef, so the control unit and the hazard unit decode the same constants.
REQ-031 One sub-module, md_arith (combinational; WIDTH-parametrised signed/unsigned multiply and divide including the REQ-020/021 special cases), feeds the pending registers; the FSM and registers reside in mult_div_unit.

Verification
REQ-032 MULT rs=0xFFFFFFFE (-2), rt=3, defaults -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 DIV rs=-7, rt=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 MTLO rs=0x1234, then MULTU 0x10000 x 0x10000 issued while busy from a prior op -> second start ignored; after an idle issue, hi=1, lo=0.
REQ-035 DIV started, flush at cycle 4 -> busy=0 next cycle, hi/lo unchanged; new MULT accepted the following cycle.
REQ-036 reset=0 mid-RUN between clock edges -> busy, hi, and lo go to 0 immediately; WIDTH=16, MULT_CYCLES=1 instance: MULT 0x8000 x 0x8000 -> hi=0x4000, lo=0 after 1 cycle.
